// File: rtl/mips_pkg.sv
// Shared definitions for the front end: instruction field layout, two-word
// opcode decoding and the fetch state encoding.
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int INSTR_W = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 9;
    localparam int RDST_MSB = 8;
    localparam int RDST_LSB = 6;
    localparam int RSRC1_MSB = 5;
    localparam int RSRC1_LSB = 3;
    localparam int RSRC2_MSB = 2;
    localparam int RSRC2_LSB = 0;

    localparam logic [6:0] OP_IADD = 7'b0101000;
    localparam logic [3:0] OP_LDM_PFX = 4'b1001;
    localparam logic [3:0] OP_LDD_PFX = 4'b1010;
    localparam logic [3:0] OP_STD_PFX = 4'b1011;

    typedef enum logic {
        FETCH = 1'b0,
        IMM   = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] rdst;
        logic [2:0] rsrc1;
        logic [2:0] rsrc2;
    } instr_fields_t;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
        f.rdst   = instr[RDST_MSB:RDST_LSB];
        f.rsrc1  = instr[RSRC1_MSB:RSRC1_LSB];
        f.rsrc2  = instr[RSRC2_MSB:RSRC2_LSB];
        return f;
    endfunction

    // LDM/LDD/STD are matched on their 4-bit prefix; the low opcode bits are free.
    function automatic logic is_two_word(input logic [6:0] opcode);
        return (opcode == OP_IADD)
            || (opcode[6:3] == OP_LDM_PFX)
            || (opcode[6:3] == OP_LDD_PFX)
            || (opcode[6:3] == OP_STD_PFX);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Clear (bubble/flush) beats hold (stall), which
// beats a normal load; a loaded entry is always valid.
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [INSTR_W-1:0] load_imm,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               d_valid,
    output logic [INSTR_W-1:0] d_instr,
    output logic [INSTR_W-1:0] d_imm,
    output logic [ADDR_W-1:0]  d_pc
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = '0;
            imm_d   = '0;
            pc_d    = '0;
        end else if (!hold) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            imm_d   = load_imm;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign d_valid = valid_q;
    assign d_instr = instr_q;
    assign d_imm   = imm_q;
    assign d_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, the FETCH/IMM state machine that assembles two-word
// instructions, and the IF/ID register feeding decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallD,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               d_valid,
    output logic [INSTR_W-1:0] d_instr,
    output logic [INSTR_W-1:0] d_imm,
    output logic [ADDR_W-1:0]  d_pc
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]  buf_pc_q, buf_pc_d;

    logic               ifid_hold;
    logic               ifid_clear;
    logic [INSTR_W-1:0] ld_instr;
    logic [INSTR_W-1:0] ld_imm;
    logic [ADDR_W-1:0]  ld_pc;

    assign imem_addr = pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        ifid_hold   = 1'b0;
        ifid_clear  = 1'b0;
        ld_instr    = imem_data;
        ld_imm      = '0;
        ld_pc       = pc_q;

        if (branch_taken) begin
            pc_d        = branch_target;
            state_d     = FETCH;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            ifid_clear  = 1'b1;
        end else if (stallD) begin
            ifid_hold = 1'b1;
        end else begin
            pc_d = pc_q + 32'd1;
            unique case (state_q)
                FETCH: begin
                    // First word of a two-word instruction: park it and bubble decode.
                    if (is_two_word(opcode_of(imem_data))) begin
                        buf_instr_d = imem_data;
                        buf_pc_d    = pc_q;
                        ifid_clear  = 1'b1;
                        state_d     = IMM;
                    end
                end
                IMM: begin
                    ld_instr = buf_instr_q;
                    ld_imm   = imem_data;
                    ld_pc    = buf_pc_q;
                    state_d  = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (ifid_hold),
        .clear      (ifid_clear),
        .load_instr (ld_instr),
        .load_imm   (ld_imm),
        .load_pc    (ld_pc),
        .d_valid    (d_valid),
        .d_instr    (d_instr),
        .d_imm      (d_imm),
        .d_pc       (d_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected decode entries are queued as each
// fetch is driven and compared when d_valid presents a new instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        d_valid;
    logic [15:0] d_instr;
    logic [15:0] d_imm;
    logic [31:0] d_pc;

    logic [15:0] mem [0:127];

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] instr;
        logic [15:0] imm;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[6:0]];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallD        (stallD),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .d_valid       (d_valid),
        .d_instr       (d_instr),
        .d_imm         (d_imm),
        .d_pc          (d_pc)
    );

    task check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task expect_instr(input logic [31:0] pc, input logic [15:0] instr, input logic [15:0] imm);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.imm   = imm;
        sb_q.push_back(e);
    endtask

    // One clock with the given controls; a new valid entry is scoreboarded.
    task apply_stimulus(input logic stall, input logic br, input logic [31:0] tgt);
        exp_t e;
        stallD        = stall;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
        if (d_valid && !stall && !rst) begin
            if (sb_q.size() == 0) begin
                check_output("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_pc", d_pc, e.pc);
                check_output("sb_instr", 32'(d_instr), 32'(e.instr));
                check_output("sb_imm", 32'(d_imm), 32'(e.imm));
            end
        end
        stallD       = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        stallD        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h0288; mem[1]  = 16'h029A; mem[2]  = 16'h02AC; mem[3] = 16'h02BE;
        mem[4]    = 16'h5000; mem[5]  = 16'h1234;
        mem[6]    = 16'h0451; mem[7]  = 16'h0462; mem[8]  = 16'h0473; mem[9] = 16'h0484;
        mem[10]   = 16'h9249; mem[11] = 16'hBEEF;
        mem[12]   = 16'hA4D1; mem[13] = 16'h7777;
        mem[7'h40] = 16'h0C0A; mem[7'h41] = 16'hB653; mem[7'h42] = 16'h00AA; mem[7'h43] = 16'h0FFF;
        mem[7'h50] = 16'h1234;
        mem[7'h60] = 16'hA4D1; mem[7'h61] = 16'h5555;
        mem[127]  = 16'h0E01;

        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rst_valid", 32'(d_valid), 32'd0);
        check_output("rst_instr", 32'(d_instr), 32'd0);
        check_output("rst_imm", 32'(d_imm), 32'd0);
        check_output("rst_pc", d_pc, 32'd0);
        rst = 1'b0;
        check_output("rst_addr", imem_addr, 32'h0);

        for (int i = 0; i < 4; i++) begin
            expect_instr(32'(i), mem[i], 16'h0);
            apply_stimulus(1'b0, 1'b0, 32'h0);
            check_output("seq_addr", imem_addr, 32'(i + 1));
        end

        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("iadd_bubble", 32'(d_valid), 32'd0);
        expect_instr(32'd4, 16'h5000, 16'h1234);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("iadd_valid", 32'(d_valid), 32'd1);
        check_output("iadd_next_addr", imem_addr, 32'd6);

        expect_instr(32'd6, mem[6], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_instr(32'd7, mem[7], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            check_output("stall_pc", d_pc, 32'd7);
            check_output("stall_valid", 32'(d_valid), 32'd1);
            check_output("stall_instr", 32'(d_instr), 32'(mem[7]));
            check_output("stall_addr", imem_addr, 32'd8);
        end
        expect_instr(32'd8, mem[8], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("release_pc", d_pc, 32'd8);
        expect_instr(32'd9, mem[9], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);

        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("ldm_bubble", 32'(d_valid), 32'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("imm_stall_valid", 32'(d_valid), 32'd0);
        check_output("imm_stall_addr", imem_addr, 32'd11);
        expect_instr(32'd10, 16'h9249, 16'hBEEF);
        apply_stimulus(1'b0, 1'b0, 32'h0);

        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("ldd_bubble", 32'(d_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'h40);
        check_output("br_valid", 32'(d_valid), 32'd0);
        check_output("br_instr", 32'(d_instr), 32'd0);
        check_output("br_pc", d_pc, 32'd0);
        check_output("br_addr", imem_addr, 32'h40);

        expect_instr(32'h40, mem[7'h40], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("std_bubble", 32'(d_valid), 32'd0);
        expect_instr(32'h41, 16'hB653, 16'h00AA);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("std_next_addr", imem_addr, 32'h43);

        apply_stimulus(1'b1, 1'b1, 32'h50);
        check_output("br_stall_valid", 32'(d_valid), 32'd0);
        check_output("br_stall_addr", imem_addr, 32'h50);
        expect_instr(32'h50, mem[7'h50], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);

        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        check_output("wrap_start", imem_addr, 32'hFFFF_FFFF);
        expect_instr(32'hFFFF_FFFF, mem[127], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_addr", imem_addr, 32'h0);
        expect_instr(32'h0, mem[0], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_next", imem_addr, 32'h1);

        apply_stimulus(1'b0, 1'b1, 32'h60);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rst_imm_pre", imem_addr, 32'h61);
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        check_output("rst_imm_addr", imem_addr, 32'h0);
        check_output("rst_imm_valid", 32'(d_valid), 32'd0);
        expect_instr(32'h0, mem[0], 16'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("post_rst_addr", imem_addr, 32'h1);

        check_output("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
